uart_rx_fsm: RTL and testbench
==============================

UART_RX_FSM -- requirements
Module: uart_rx_fsm

Interface
- REQ-001 SHALL have parameter IN_DATA_WIDTH, default 8, the number of data bits per frame.
- REQ-002 SHALL have port CLK, input, 1 bit: the single clock.
- REQ-003 SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
- REQ-004 SHALL have port RX_IN, input, 1 bit: serial line, already synchronised, idle high.
- REQ-005 SHALL have port PAR_EN, input, 1 bit: the frame carries a parity bit.
- REQ-006 SHALL have port Prescale, input, 6 bits: oversampling ratio; legal values 8, 16, 32.
- REQ-007 SHALL have port strt_glitch, input, 1 bit: start checker found start bit high.
- REQ-008 SHALL have port par_err, input, 1 bit: parity checker mismatch.
- REQ-009 SHALL have port stp_err, input, 1 bit: stop checker found stop bit low.
- REQ-010 SHALL have port edge_cnt, output, 6 bits: oversampling edge index within the current bit.
- REQ-011 SHALL have port bit_cnt, output, 4 bits: bit index within the frame (0 = start).
- REQ-012 SHALL have ports dat_samp_en, deser_en, strt_chk_en, par_chk_en and stp_chk_en, outputs, 1 bit each: enables for the sampler, deserializer and checkers.
- REQ-013 SHALL have ports data_valid, parity_error and framing_error, outputs, 1 bit each: single-cycle frame-result pulses.

Function
- REQ-014 SHALL implement states IDLE, START, DATA, PARITY, STOP.
- REQ-015 IDLE -> START SHALL occur on the first CLK edge with RX_IN==0; edge_cnt and bit_cnt SHALL be 0 on entry to START.
- REQ-016 edge_cnt SHALL increment every cycle outside IDLE and wrap from Prescale-1 to 0; bit_cnt SHALL increment on each wrap.
- REQ-017 Any Prescale other than 8, 16 or 32 SHALL be treated as 8.
- REQ-018 dat_samp_en SHALL be 1 in every state except IDLE.
- REQ-019 strt_chk_en, deser_en, par_chk_en and stp_chk_en SHALL each be 1 only in START, DATA, PARITY and STOP respectively, and only on the cycle edge_cnt == (Prescale>>1)+2.
- REQ-020 START: at edge_cnt == Prescale-1, strt_glitch==1 -> IDLE with counters cleared and no pulse; otherwise -> DATA.
- REQ-021 DATA SHALL span bit_cnt 1..IN_DATA_WIDTH, then go to PARITY if PAR_EN==1, else to STOP.
- REQ-022 PAR_EN SHALL be latched on the IDLE->START transition; a change mid-frame SHALL have no effect on the current frame.
- REQ-023 PARITY: par_err SHALL be sampled at edge_cnt == Prescale-1 into an internal flag, then the block SHALL go to STOP.
- REQ-024 STOP SHALL end at edge_cnt == (Prescale>>1)+3, i.e. half a bit early for resynchronisation, and return to IDLE.
- REQ-025 At STOP end, exactly one result pulse SHALL be issued: framing_error if stp_err==1; else parity_error if the flag is set; else data_valid.
- REQ-026 Result pulses SHALL be registered, high for exactly one cycle, and mutually exclusive.
- REQ-027 A frame SHALL be at most IN_DATA_WIDTH+3 bits, so bit_cnt SHALL never exceed 10 at the default width.

Reset
- REQ-028 RST==1 at any CLK edge, including mid-frame, SHALL force IDLE, clear edge_cnt, bit_cnt and the parity flag, and drive every output to 0 on that edge.
- REQ-029 A partial frame cut by reset SHALL produce no result pulse.

Structure
- REQ-030 State encodings and the legal prescale constants (8, 16, 32) SHALL live in the shared uart_rx_pkg package.
- REQ-031 The edge and bit counters SHALL be one sub-module, edge_bit_counter, enabled by the FSM and with a synchronous clear.

Verification
- REQ-032 Prescale=8, PAR_EN=0, frame 0x55 -> deser_en pulses 8 times at edge_cnt==6, then data_valid for 1 cycle, back in IDLE.
- REQ-033 Prescale=16, PAR_EN=1, checker returns par_err=1 -> parity_error pulse only, no data_valid.
- REQ-034 Prescale=32, RX_IN low for 4 cycles, strt_glitch=1 -> IDLE after one bit time, no pulses, no deser_en.
- REQ-035 Stop bit low with stp_err=1 -> framing_error only, even when par_err is also 1.
- REQ-036 RST asserted in DATA at bit_cnt=4 -> next cycle all outputs 0 and state IDLE; the following clean frame 0xA3 -> data_valid.
- REQ-037 Two back-to-back frames with no idle gap -> two data_valid pulses, and the second start bit is detected within 1 cycle of the STOP exit.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive controller: FSM state encoding,
// the supported oversampling ratios and the prescale legalisation helper.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    localparam logic [5:0] PRESCALE_8  = 6'd8;
    localparam logic [5:0] PRESCALE_16 = 6'd16;
    localparam logic [5:0] PRESCALE_32 = 6'd32;

    // Unsupported ratios fall back to 8x so the bit timing stays bounded.
    function automatic logic [5:0] legal_prescale(input logic [5:0] p);
        case (p)
            PRESCALE_16: legal_prescale = PRESCALE_16;
            PRESCALE_32: legal_prescale = PRESCALE_32;
            default:     legal_prescale = PRESCALE_8;
        endcase
    endfunction

endpackage

// File: rtl/edge_bit_counter.sv
// Oversampling edge counter and frame bit counter. The edge index wraps at
// prescale-1 and each wrap advances the bit index; clear wins over enable.
module edge_bit_counter (
    input  logic       CLK,
    input  logic       RST,
    input  logic       en_i,
    input  logic       clr_i,
    input  logic [5:0] prescale_i,
    output logic [5:0] edge_cnt_o,
    output logic [3:0] bit_cnt_o
);

    logic [5:0] edge_q, edge_d;
    logic [3:0] bit_q, bit_d;

    // Next-count logic.
    always_comb begin
        edge_d = edge_q;
        bit_d  = bit_q;
        if (clr_i) begin
            edge_d = 6'd0;
            bit_d  = 4'd0;
        end else if (en_i) begin
            if (edge_q == prescale_i - 6'd1) begin
                edge_d = 6'd0;
                bit_d  = bit_q + 4'd1;
            end else begin
                edge_d = edge_q + 6'd1;
            end
        end else begin
            edge_d = edge_q;
            bit_d  = bit_q;
        end
    end

    // Counter registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            edge_q <= 6'd0;
            bit_q  <= 4'd0;
        end else begin
            edge_q <= edge_d;
            bit_q  <= bit_d;
        end
    end

    assign edge_cnt_o = edge_q;
    assign bit_cnt_o  = bit_q;

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receive frame controller: walks start/data/parity/stop bits, gates the
// sampler and checkers, and issues one registered result pulse per frame.
module uart_rx_fsm
    import uart_rx_pkg::*;
#(
    parameter int IN_DATA_WIDTH = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX_IN,
    input  logic       PAR_EN,
    input  logic [5:0] Prescale,
    input  logic       strt_glitch,
    input  logic       par_err,
    input  logic       stp_err,
    output logic [5:0] edge_cnt,
    output logic [3:0] bit_cnt,
    output logic       dat_samp_en,
    output logic       deser_en,
    output logic       strt_chk_en,
    output logic       par_chk_en,
    output logic       stp_chk_en,
    output logic       data_valid,
    output logic       parity_error,
    output logic       framing_error
);

    localparam logic [3:0] DATA_LAST = 4'(IN_DATA_WIDTH);

    rx_state_e  state_q, state_d;
    logic       par_en_q, par_en_d;
    logic       par_flag_q, par_flag_d;
    logic       dv_q, dv_d;
    logic       pe_q, pe_d;
    logic       fe_q, fe_d;
    logic       cnt_en_s, cnt_clr_s;
    logic [5:0] prescale_s;
    logic       last_edge_s, samp_pt_s, stop_end_s;

    assign prescale_s  = legal_prescale(Prescale);
    assign last_edge_s = (edge_cnt == prescale_s - 6'd1);
    assign samp_pt_s   = (edge_cnt == (prescale_s >> 1) + 6'd2);
    // The stop bit is cut short so the next start edge is caught in time.
    assign stop_end_s  = (edge_cnt == (prescale_s >> 1) + 6'd3);

    edge_bit_counter u_cnt (
        .CLK        (CLK),
        .RST        (RST),
        .en_i       (cnt_en_s),
        .clr_i      (cnt_clr_s),
        .prescale_i (prescale_s),
        .edge_cnt_o (edge_cnt),
        .bit_cnt_o  (bit_cnt)
    );

    // Next-state, counter control and result decode.
    always_comb begin
        state_d    = state_q;
        par_en_d   = par_en_q;
        par_flag_d = par_flag_q;
        cnt_en_s   = 1'b0;
        cnt_clr_s  = 1'b0;
        dv_d       = 1'b0;
        pe_d       = 1'b0;
        fe_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (!RX_IN) begin
                    state_d    = START;
                    par_en_d   = PAR_EN;
                    par_flag_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                cnt_en_s = 1'b1;
                if (last_edge_s) begin
                    if (strt_glitch) begin
                        state_d   = IDLE;
                        cnt_clr_s = 1'b1;
                    end else begin
                        state_d = DATA;
                    end
                end else begin
                    state_d = START;
                end
            end
            DATA: begin
                cnt_en_s = 1'b1;
                if (last_edge_s && (bit_cnt == DATA_LAST)) begin
                    state_d = par_en_q ? PARITY : STOP;
                end else begin
                    state_d = DATA;
                end
            end
            PARITY: begin
                cnt_en_s = 1'b1;
                if (last_edge_s) begin
                    par_flag_d = par_err;
                    state_d    = STOP;
                end else begin
                    state_d = PARITY;
                end
            end
            STOP: begin
                cnt_en_s = 1'b1;
                if (stop_end_s) begin
                    state_d    = IDLE;
                    cnt_clr_s  = 1'b1;
                    par_flag_d = 1'b0;
                    fe_d       = stp_err;
                    pe_d       = !stp_err && par_flag_q;
                    dv_d       = !stp_err && !par_flag_q;
                end else begin
                    state_d = STOP;
                end
            end
            default: begin
                state_d   = IDLE;
                cnt_clr_s = 1'b1;
            end
        endcase
    end

    // State, latched frame options and result pulse registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            par_en_q   <= 1'b0;
            par_flag_q <= 1'b0;
            dv_q       <= 1'b0;
            pe_q       <= 1'b0;
            fe_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            par_en_q   <= par_en_d;
            par_flag_q <= par_flag_d;
            dv_q       <= dv_d;
            pe_q       <= pe_d;
            fe_q       <= fe_d;
        end
    end

    assign dat_samp_en   = (state_q != IDLE);
    assign strt_chk_en   = (state_q == START)  && samp_pt_s;
    assign deser_en      = (state_q == DATA)   && samp_pt_s;
    assign par_chk_en    = (state_q == PARITY) && samp_pt_s;
    assign stp_chk_en    = (state_q == STOP)   && samp_pt_s;
    assign data_valid    = dv_q;
    assign parity_error  = pe_q;
    assign framing_error = fe_q;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Scoreboard bench for uart_rx_fsm: frame tasks queue the expected result,
// a negedge monitor pops and compares whenever a result pulse appears.
module tb_uart_rx_fsm;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       RX_IN = 1'b1;
    logic       PAR_EN = 1'b0;
    logic [5:0] Prescale = 6'd8;
    logic       strt_glitch = 1'b0;
    logic       par_err = 1'b0;
    logic       stp_err = 1'b0;
    logic [5:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en;
    logic       data_valid, parity_error, framing_error;

    uart_rx_fsm #(.IN_DATA_WIDTH(8)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .RX_IN         (RX_IN),
        .PAR_EN        (PAR_EN),
        .Prescale      (Prescale),
        .strt_glitch   (strt_glitch),
        .par_err       (par_err),
        .stp_err       (stp_err),
        .edge_cnt      (edge_cnt),
        .bit_cnt       (bit_cnt),
        .dat_samp_en   (dat_samp_en),
        .deser_en      (deser_en),
        .strt_chk_en   (strt_chk_en),
        .par_chk_en    (par_chk_en),
        .stp_chk_en    (stp_chk_en),
        .data_valid    (data_valid),
        .parity_error  (parity_error),
        .framing_error (framing_error)
    );

    // res: 1 = data_valid, 2 = parity_error, 3 = framing_error
    typedef struct {
        int res;
        int ndeser;
        int npar;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   deser_run = 0, par_run = 0;
    int   deser_total = 0, strt_total = 0, pulse_total = 0;
    int   last_pulse_cyc = -100;
    int   gap_ref = -1;
    bit   gap_done = 1'b0;
    logic samp_prev = 1'b0;

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic int eff_p(input logic [5:0] p);
        return (p == 6'd16 || p == 6'd32) ? int'(p) : 8;
    endfunction

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge CLK) begin
        if (RST) begin
            deser_run = 0;
            par_run   = 0;
        end else begin
            if (deser_en) begin
                deser_run++;
                deser_total++;
                check("deser_edge", int'(edge_cnt), eff_p(Prescale) / 2 + 2);
            end
            if (par_chk_en) par_run++;
            if (strt_chk_en) strt_total++;
            if (dat_samp_en) check("bit_cnt_max", int'(bit_cnt <= 4'd10), 1);
            if (data_valid || parity_error || framing_error) begin
                pulse_total++;
                last_pulse_cyc = cyc;
                check("pulse_onehot", $countones({data_valid, parity_error, framing_error}), 1);
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_pulse: got dv=%0b pe=%0b fe=%0b expected none",
                             data_valid, parity_error, framing_error);
                end else begin
                    mon_e = q.pop_front();
                    check("result", data_valid ? 1 : (parity_error ? 2 : 3), mon_e.res);
                    check("deser_count", deser_run, mon_e.ndeser);
                    check("par_chk_count", par_run, mon_e.npar);
                end
                deser_run = 0;
                par_run   = 0;
            end
            if (gap_ref >= 0 && pulse_total == gap_ref && dat_samp_en && !samp_prev) begin
                check("b2b_restart_gap", int'((cyc - last_pulse_cyc) <= 1), 1);
                gap_done = 1'b1;
                gap_ref  = -1;
            end
        end
        samp_prev = dat_samp_en;
    end

    task automatic drive_bit(input logic v, input int n);
        RX_IN = v;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic [5:0] ps, input bit pen,
                              input bit perr, input bit serr, input bit flip_par,
                              input bit push, input int res, input int nd, input int np);
        int   p;
        exp_t e;
        p        = eff_p(ps);
        Prescale = ps;
        PAR_EN   = pen;
        par_err  = perr;
        stp_err  = serr;
        if (push) begin
            e.res    = res;
            e.ndeser = nd;
            e.npar   = np;
            q.push_back(e);
        end
        drive_bit(1'b0, p);
        if (flip_par) PAR_EN = ~PAR_EN;
        for (int i = 0; i < 8; i++) drive_bit(d[i], p);
        if (pen) drive_bit((^d) ^ perr, p);
        // A bad stop bit is only held low for half a bit so the line is high
        // again before the receiver goes back to looking for a start edge.
        if (serr) begin
            drive_bit(1'b0, p / 2);
            drive_bit(1'b1, p - p / 2);
        end else begin
            drive_bit(1'b1, p);
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 300 && q.size() != 0; k++) @(posedge CLK);
        repeat (4) @(posedge CLK);
        #1;
        check("drain_queue_empty", q.size(), 0);
    endtask

    function automatic int all_outs();
        return int'({edge_cnt, bit_cnt, dat_samp_en, deser_en, strt_chk_en, par_chk_en,
                     stp_chk_en, data_valid, parity_error, framing_error});
    endfunction

    initial begin
        int  ref_deser, ref_strt, ref_pulse;
        bit  found;

        repeat (3) @(posedge CLK);
        #1;
        check("reset_outputs", all_outs(), 0);
        check("reset_edge_cnt", int'(edge_cnt), 0);
        check("reset_bit_cnt", int'(bit_cnt), 0);
        RST = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("idle_outputs", all_outs(), 0);

        // 0x55 at 8x, no parity
        send_frame(8'h55, 6'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 8, 0);
        drain();
        check("idle_after_55", int'(dat_samp_en), 0);

        // 16x with parity, parity checker reports an error
        send_frame(8'h3C, 6'd16, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2, 8, 1);
        drain();

        // 32x start glitch
        ref_deser   = deser_total;
        ref_strt    = strt_total;
        ref_pulse   = pulse_total;
        Prescale    = 6'd32;
        strt_glitch = 1'b1;
        RX_IN       = 1'b0;
        repeat (4) @(posedge CLK);
        #1;
        RX_IN = 1'b1;
        repeat (40) @(posedge CLK);
        #1;
        strt_glitch = 1'b0;
        check("glitch_idle", int'(dat_samp_en), 0);
        check("glitch_no_deser", deser_total - ref_deser, 0);
        check("glitch_no_pulse", pulse_total - ref_pulse, 0);
        check("glitch_strt_chk", strt_total - ref_strt, 1);
        check("glitch_counters", int'({edge_cnt, bit_cnt}), 0);

        // stop error wins over parity error
        send_frame(8'hF0, 6'd16, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3, 8, 1);
        drain();

        // reset in the middle of the data bits
        ref_pulse = pulse_total;
        found     = 1'b0;
        fork
            send_frame(8'hFF, 6'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
            begin
                for (int k = 0; k < 200 && !found; k++) begin
                    @(negedge CLK);
                    if (bit_cnt == 4'd4 && edge_cnt == 6'd2) found = 1'b1;
                end
                check("reset_point_reached", int'(found), 1);
                RST = 1'b1;
                @(posedge CLK);
                #1;
                check("midframe_reset_outputs", all_outs(), 0);
                @(negedge CLK);
                #1;
                RST = 1'b0;
            end
        join
        repeat (20) @(posedge CLK);
        #1;
        check("post_reset_idle", int'(dat_samp_en), 0);
        check("post_reset_no_pulse", pulse_total - ref_pulse, 0);

        // clean frame after the reset
        send_frame(8'hA3, 6'd16, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1, 8, 1);
        drain();

        // two frames with no idle gap
        gap_ref = pulse_total + 1;
        send_frame(8'h12, 6'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 8, 0);
        send_frame(8'h34, 6'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 8, 0);
        drain();
        check("b2b_restart_seen", int'(gap_done), 1);

        // illegal prescale behaves as 8x; PAR_EN raised mid-frame is ignored
        send_frame(8'h81, 6'd12, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1, 8, 0);
        drain();
        PAR_EN = 1'b0;

        check("final_queue_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
